// File: rtl/mfgate_rr_sched_pkg.sv
// Shared constants for the mfGate round-robin scheduler.
// Gate op encodings and FSM state encodings.
package mfgate_rr_sched_pkg;

    localparam logic [1:0] OP_PASS_X   = 2'b00;
    localparam logic [1:0] OP_PASS_Y_A = 2'b10;
    localparam logic [1:0] OP_PASS_Y_B = 2'b01;
    localparam logic [1:0] OP_INV_X    = 2'b11;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EVAL = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

endpackage

// File: rtl/mfgate_rr_sched_if.sv
// Request/response bundle between requesters, consumer and scheduler.
// master = requester/consumer side, slave = scheduler side.
interface mfgate_rr_sched_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
);
    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ-1:0]   req_x;
    logic [N_REQ-1:0]   req_y;
    logic [2*N_REQ-1:0] req_op;
    logic [N_REQ-1:0]   req_ready;
    logic               rsp_valid;
    logic               rsp_ready;
    logic               rsp_f;
    logic [ID_W-1:0]    rsp_id;

    modport master (
        output req_valid, req_x, req_y, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_f, rsp_id
    );

    modport slave (
        input  req_valid, req_x, req_y, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_f, rsp_id
    );
endinterface

// File: rtl/mfGate.sv
// Multifunction gate: {a,b}=00 -> x, 11 -> ~x, 01/10 -> y.
module mfGate (
    input  logic a,
    input  logic b,
    input  logic x,
    input  logic y,
    output logic f
);
    assign f = (~a & ~b & x) | (a & b & ~x) | ((a ^ b) & y);
endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first set request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [ID_W-1:0]  i_ptr,
    output logic [N_REQ-1:0] o_grant,
    output logic [ID_W-1:0]  o_idx
);
    logic [2*N_REQ-1:0] w_dbl;
    logic [N_REQ-1:0]   w_rot;
    logic               w_found;
    int                 w_pos;

    // Rotate so bit 0 of w_rot is the requester at ptr.
    assign w_dbl = {i_req, i_req};
    assign w_rot = N_REQ'(w_dbl >> i_ptr);

    always_comb begin
        w_found = 1'b0;
        w_pos   = 0;
        o_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!w_found && w_rot[k]) begin
                w_found = 1'b1;
                w_pos   = int'(i_ptr) + k;
                if (w_pos >= N_REQ) w_pos = w_pos - N_REQ;
                o_idx   = ID_W'(w_pos);
            end
        end
        o_grant = w_found ? (N_REQ'(1) << o_idx) : '0;
    end
endmodule

// File: rtl/mfgate_rr_sched.sv
// Shares one mfGate between N_REQ requesters with round-robin grant,
// registered operands/result and a saturating completion counter.
module mfgate_rr_sched
    import mfgate_rr_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    mfgate_rr_sched_if.slave bus,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);
    logic [1:0]       r_state;
    logic [ID_W-1:0]  r_ptr;
    logic             r_x;
    logic             r_y;
    logic [1:0]       r_op;
    logic [ID_W-1:0]  r_id;
    logic             r_f;
    logic [ID_W-1:0]  r_rsp_id;
    logic [CNT_W-1:0] r_cnt;

    logic [N_REQ-1:0] w_grant;
    logic [ID_W-1:0]  w_gidx;
    logic             w_any;
    logic             w_x;
    logic             w_y;
    logic [1:0]       w_op;
    logic             w_f;

    rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
        .i_req   (bus.req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_gidx)
    );

    // Gate sees only captured operands.
    mfGate u_gate (
        .a (r_op[1]),
        .b (r_op[0]),
        .x (r_x),
        .y (r_y),
        .f (w_f)
    );

    assign w_any = |bus.req_valid;
    assign w_x   = |(bus.req_x & w_grant);
    assign w_y   = |(bus.req_y & w_grant);

    always_comb begin
        w_op = 2'b00;
        for (int i = 0; i < N_REQ; i++) begin
            w_op = w_op | (bus.req_op[2*i +: 2] & {2{w_grant[i]}});
        end
    end

    assign bus.req_ready = (r_state == IDLE) ? w_grant : '0;
    assign bus.rsp_valid = (r_state == RESP);
    assign bus.rsp_f     = r_f;
    assign bus.rsp_id    = r_rsp_id;
    assign busy          = (r_state != IDLE);
    assign op_count      = r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_ptr    <= '0;
            r_x      <= 1'b0;
            r_y      <= 1'b0;
            r_op     <= 2'b00;
            r_id     <= '0;
            r_f      <= 1'b0;
            r_rsp_id <= '0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_x     <= w_x;
                        r_y     <= w_y;
                        r_op    <= w_op;
                        r_id    <= w_gidx;
                        r_ptr   <= (w_gidx == ID_W'(N_REQ - 1)) ?
                                   '0 : w_gidx + ID_W'(1);
                        r_state <= EVAL;
                    end
                end
                EVAL: begin
                    r_f      <= w_f;
                    r_rsp_id <= r_id;
                    r_state  <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        if (r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
